// File: rtl/cam_op_sequencer.sv
// cam_op_sequencer: one-command-at-a-time sequencer driving CAM_Subarray pins,
// capturing search tags into an accumulator and returning tag plus hit count.
module cam_op_sequencer #(
  parameter int DATA_W = 32,
  parameter int CMP_AW = 10,
  parameter int PPG_AW = 6,
  parameter int HIT_W  = 6
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic              cmd_addr_select,
  input  logic [CMP_AW-1:0] cmd_cmp_addr,
  input  logic [PPG_AW-1:0] cmd_ppg_addr,
  input  logic [1:0]        cmd_cmp_data,
  input  logic [1:0]        cmd_ppg_data,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [DATA_W-1:0] cmd_tag,
  input  logic              cmd_upd_val,
  input  logic              cmd_chain,
  input  logic [1:0]        cmd_acc,
  output logic              sa_chip_enable,
  output logic [2:0]        sa_operation_mode,
  output logic              sa_addr_select,
  output logic [CMP_AW-1:0] sa_cmp_addr,
  output logic [PPG_AW-1:0] sa_ppg_addr,
  output logic [1:0]        sa_cmp_data,
  output logic [1:0]        sa_ppg_data,
  output logic [DATA_W-1:0] sa_data_in,
  output logic [DATA_W-1:0] sa_tag_in,
  output logic              sa_update_signal,
  input  logic [DATA_W-1:0] sa_tag_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_tag,
  output logic [HIT_W-1:0]  rsp_hits,
  output logic              rsp_err
);
  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, UPDATE, RESP} state_t;
  state_t state_q, state_d;
  logic wr_q, chain_q, upd_q;
  logic [1:0] accm_q;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [HIT_W-1:0] hits_q, hits_d;
  logic accept, illegal;
  assign accept  = cmd_valid && cmd_ready;
  assign illegal = cmd_op == 3'b111;
  assign rsp_tag  = acc_q;
  assign rsp_hits = hits_q;
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    hits_d  = hits_q;
    unique case (state_q)
      IDLE:    state_d = accept ? (illegal ? RESP : ISSUE) : IDLE;
      ISSUE:   state_d = wr_q ? RESP : CAPTURE;
      CAPTURE: begin
        acc_d   = accm_q == 2'b01 ? acc_q & sa_tag_out :
                  accm_q == 2'b10 ? acc_q | sa_tag_out : sa_tag_out;
        hits_d  = HIT_W'($countones(acc_d));
        state_d = chain_q ? UPDATE : RESP;
      end
      UPDATE:  state_d = RESP;
      RESP:    state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q           <= IDLE;
      wr_q              <= 1'b0;
      chain_q           <= 1'b0;
      upd_q             <= 1'b0;
      accm_q            <= 2'b00;
      acc_q             <= '0;
      hits_q            <= '0;
      cmd_ready         <= 1'b0;
      rsp_valid         <= 1'b0;
      rsp_err           <= 1'b0;
      sa_chip_enable    <= 1'b0;
      sa_operation_mode <= 3'b000;
      sa_addr_select    <= 1'b0;
      sa_cmp_addr       <= '0;
      sa_ppg_addr       <= '0;
      sa_cmp_data       <= 2'b00;
      sa_ppg_data       <= 2'b00;
      sa_data_in        <= '0;
      sa_tag_in         <= '0;
      sa_update_signal  <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      hits_q         <= hits_d;
      cmd_ready      <= state_d == IDLE;
      rsp_valid      <= state_d == RESP;
      sa_chip_enable <= state_d == ISSUE || state_d == UPDATE;
      if (state_q == RESP && rsp_ready) rsp_err <= 1'b0;
      if (state_q == IDLE && accept) begin
        wr_q    <= cmd_op[2:1] == 2'b00;
        chain_q <= cmd_chain;
        upd_q   <= cmd_upd_val;
        accm_q  <= cmd_acc;
        rsp_err <= illegal;
        // illegal commands never reach the array, so its pins keep their last value
        if (!illegal) begin
          sa_operation_mode <= cmd_op;
          sa_addr_select    <= cmd_addr_select;
          sa_cmp_addr       <= cmd_cmp_addr;
          sa_ppg_addr       <= cmd_ppg_addr;
          sa_cmp_data       <= cmd_cmp_data;
          sa_ppg_data       <= cmd_ppg_data;
          sa_data_in        <= cmd_data;
          sa_tag_in         <= cmd_tag;
          sa_update_signal  <= cmd_upd_val;
        end
      end
      if (state_d == UPDATE) begin
        sa_operation_mode <= 3'b001;
        sa_addr_select    <= 1'b0;
        sa_tag_in         <= acc_d;
        sa_update_signal  <= upd_q;
      end
    end
  end
endmodule

// File: tb/tb_cam_op_sequencer.sv
// tb_cam_op_sequencer: directed and random commands against a behavioural
// accumulator/latency model, with a simple subarray returning tags after searches.
module tb_cam_op_sequencer;
  localparam int DW = 32, CW = 10, PW = 6, HW = 6;
  logic CLK = 0, RST_N = 1;
  logic cmd_valid = 0, cmd_ready;
  logic [2:0] cmd_op = 0;
  logic cmd_addr_select = 0;
  logic [CW-1:0] cmd_cmp_addr = 0;
  logic [PW-1:0] cmd_ppg_addr = 0;
  logic [1:0] cmd_cmp_data = 0, cmd_ppg_data = 0, cmd_acc = 0;
  logic [DW-1:0] cmd_data = 0, cmd_tag = 0;
  logic cmd_upd_val = 0, cmd_chain = 0;
  logic sa_chip_enable, sa_addr_select, sa_update_signal;
  logic [2:0] sa_operation_mode;
  logic [CW-1:0] sa_cmp_addr;
  logic [PW-1:0] sa_ppg_addr;
  logic [1:0] sa_cmp_data, sa_ppg_data;
  logic [DW-1:0] sa_data_in, sa_tag_in, sa_tag_out;
  logic rsp_valid, rsp_ready = 0, rsp_err;
  logic [DW-1:0] rsp_tag;
  logic [HW-1:0] rsp_hits;

  cam_op_sequencer #(.DATA_W(DW), .CMP_AW(CW), .PPG_AW(PW), .HIT_W(HW)) dut (
    .CLK(CLK), .RST_N(RST_N), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr_select(cmd_addr_select), .cmd_cmp_addr(cmd_cmp_addr),
    .cmd_ppg_addr(cmd_ppg_addr), .cmd_cmp_data(cmd_cmp_data), .cmd_ppg_data(cmd_ppg_data),
    .cmd_data(cmd_data), .cmd_tag(cmd_tag), .cmd_upd_val(cmd_upd_val), .cmd_chain(cmd_chain),
    .cmd_acc(cmd_acc), .sa_chip_enable(sa_chip_enable), .sa_operation_mode(sa_operation_mode),
    .sa_addr_select(sa_addr_select), .sa_cmp_addr(sa_cmp_addr), .sa_ppg_addr(sa_ppg_addr),
    .sa_cmp_data(sa_cmp_data), .sa_ppg_data(sa_ppg_data), .sa_data_in(sa_data_in),
    .sa_tag_in(sa_tag_in), .sa_update_signal(sa_update_signal), .sa_tag_out(sa_tag_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag), .rsp_hits(rsp_hits),
    .rsp_err(rsp_err)
  );

  always #5 CLK = ~CLK;

  int total = 0, bad = 0;
  logic [DW-1:0] acc_m = 0, tag_src = 0;

  // Subarray stand-in: a search sampled at an edge presents its tag for one cycle, otherwise noise.
  always @(posedge CLK)
    sa_tag_out <= (sa_chip_enable && sa_operation_mode inside {[3'd2:3'd6]}) ? tag_src : DW'($urandom);

  logic c_as;
  logic [CW-1:0] c_ca;
  logic [PW-1:0] c_pa;
  logic [1:0] c_cd, c_pd;
  int lat, ce_n;
  logic [DW-1:0] r_tag;
  logic [HW-1:0] r_hits;
  logic r_err, rdy_seen, stable, post_ok;
  logic [2:0] i_mode, u_mode;
  logic i_as, i_upd, u_as, u_upd;
  logic [CW-1:0] i_ca;
  logic [PW-1:0] i_pa;
  logic [1:0] i_cd, i_pd;
  logic [DW-1:0] i_din, i_tin, u_tin;

  function automatic int exp_lat(input logic [2:0] op, input logic chain);
    return op == 3'd7 ? 1 : op < 3'd2 ? 2 : chain ? 4 : 3;
  endfunction

  function automatic int exp_ce(input logic [2:0] op, input logic chain);
    return op == 3'd7 ? 0 : (op >= 3'd2 && chain) ? 2 : 1;
  endfunction

  function automatic void model(input logic [2:0] op, input logic [1:0] am, input logic [DW-1:0] tout);
    if (op >= 3'd2 && op <= 3'd6) acc_m = am == 2'b01 ? acc_m & tout : am == 2'b10 ? acc_m | tout : tout;
  endfunction

  task automatic scramble();
    cmd_op = 3'($urandom); cmd_addr_select = 1'($urandom); cmd_cmp_addr = CW'($urandom);
    cmd_ppg_addr = PW'($urandom); cmd_cmp_data = 2'($urandom); cmd_ppg_data = 2'($urandom);
    cmd_data = $urandom; cmd_tag = $urandom; cmd_upd_val = 1'($urandom);
    cmd_chain = 1'($urandom); cmd_acc = 2'($urandom);
  endtask

  task automatic send(input logic [2:0] op, input logic chain, input logic [1:0] am, input logic upd,
                      input logic [DW-1:0] data, input logic [DW-1:0] tag, input logic [DW-1:0] tout,
                      input int hold);
    int n;
    logic got;
    lat = 0; ce_n = 0; rdy_seen = 0; stable = 1; post_ok = 0; got = 0;
    tag_src = tout; rsp_ready = hold == 0;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
    if (cmd_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL ready_wait got=%b want=1", cmd_ready);
      return;
    end
    cmd_op = op; cmd_chain = chain; cmd_acc = am; cmd_upd_val = upd; cmd_data = data; cmd_tag = tag;
    cmd_addr_select = c_as; cmd_cmp_addr = c_ca; cmd_ppg_addr = c_pa; cmd_cmp_data = c_cd; cmd_ppg_data = c_pd;
    cmd_valid = 1;
    @(posedge CLK); #1;
    cmd_valid = 0;
    scramble();
    for (n = 1; n <= 20 && !got; n++) begin
      @(negedge CLK);
      if (cmd_ready) rdy_seen = 1;
      if (sa_chip_enable) begin
        ce_n++;
        if (ce_n == 1) begin
          i_mode = sa_operation_mode; i_as = sa_addr_select; i_ca = sa_cmp_addr; i_pa = sa_ppg_addr;
          i_cd = sa_cmp_data; i_pd = sa_ppg_data; i_din = sa_data_in; i_tin = sa_tag_in; i_upd = sa_update_signal;
        end else begin
          u_mode = sa_operation_mode; u_as = sa_addr_select; u_tin = sa_tag_in; u_upd = sa_update_signal;
        end
      end
      if (rsp_valid) begin got = 1; lat = n; r_tag = rsp_tag; r_hits = rsp_hits; r_err = rsp_err; end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL rsp_wait got=%b want=1", rsp_valid);
      rsp_ready = 0;
      return;
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge CLK);
      if (rsp_valid !== 1'b1 || rsp_tag !== r_tag || rsp_hits !== r_hits || rsp_err !== r_err) stable = 0;
      if (cmd_ready) rdy_seen = 1;
    end
    rsp_ready = 1;
    @(posedge CLK); #1;
    rsp_ready = 0;
    @(negedge CLK);
    post_ok = rsp_valid === 1'b0 && cmd_ready === 1'b1 && rsp_err === 1'b0 && sa_chip_enable === 1'b0;
  endtask

  task automatic test_reset();
    #2 RST_N = 0;
    repeat (3) @(negedge CLK);
    total++;
    if ({cmd_ready, rsp_valid, rsp_err, sa_chip_enable} !== 4'b0 || rsp_tag !== 0 || rsp_hits !== 0 || sa_data_in !== 0) begin
      bad++;
      $display("FAIL reset_outputs got=%b%b%b%b tag=%h hits=%0d want all 0", cmd_ready, rsp_valid, rsp_err, sa_chip_enable, rsp_tag, rsp_hits);
    end
    RST_N = 1;
    repeat (2) @(negedge CLK);
    total++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL reset_idle got ready=%b valid=%b want 1/0", cmd_ready, rsp_valid);
    end
    acc_m = 0;
  endtask

  task automatic test_write();
    c_as = 1; c_ca = 10'h155; c_pa = 6'h2a; c_cd = 2'b10; c_pd = 2'b01;
    send(3'd0, 1'b0, 2'b00, 1'b0, 32'hFFFFFFFF, 32'h12345678, 32'h0, 0);
    total++;
    if (lat !== 2 || ce_n !== 1) begin bad++; $display("FAIL write_timing got lat=%0d ce=%0d want 2/1", lat, ce_n); end
    total++;
    if (i_mode !== 3'd0 || i_din !== 32'hFFFFFFFF || i_as !== 1'b1 || i_ca !== 10'h155 || i_pa !== 6'h2a || i_cd !== 2'b10 || i_pd !== 2'b01 || i_tin !== 32'h12345678) begin
      bad++; $display("FAIL write_pins got mode=%0d din=%h as=%b ca=%h tin=%h", i_mode, i_din, i_as, i_ca, i_tin);
    end
    total++;
    if (r_tag !== 0 || r_hits !== 0 || r_err !== 0 || !post_ok) begin
      bad++; $display("FAIL write_rsp got tag=%h hits=%0d err=%b post=%b want 0/0/0/1", r_tag, r_hits, r_err, post_ok);
    end
  endtask

  task automatic test_search();
    logic [2:0] ops [4] = '{3'd2, 3'd3, 3'd4, 3'd6};
    logic [1:0] ams [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [DW-1:0] touts [4] = '{32'hAAAAAAAA, 32'h0000FFFF, 32'h80000000, 32'hFFFFFFFF};
    logic [DW-1:0] tags [4] = '{32'hAAAAAAAA, 32'h0000AAAA, 32'h8000AAAA, 32'hFFFFFFFF};
    int hits [4] = '{16, 8, 9, 32};
    c_as = 0; c_ca = 10'h020; c_pa = 6'h05; c_cd = 2'b01; c_pd = 2'b11;
    for (int i = 0; i < 4; i++) begin
      send(ops[i], 1'b0, ams[i], 1'b0, 32'h0, 32'h0, touts[i], 0);
      model(ops[i], ams[i], touts[i]);
      total++;
      if (lat !== 3 || ce_n !== 1 || i_mode !== ops[i] || i_ca !== 10'h020 || i_cd !== 2'b01) begin
        bad++; $display("FAIL search%0d_issue got lat=%0d ce=%0d mode=%0d ca=%h", i, lat, ce_n, i_mode, i_ca);
      end
      total++;
      if (r_tag !== tags[i] || r_tag !== acc_m || int'(r_hits) != hits[i] || !post_ok) begin
        bad++; $display("FAIL search%0d_rsp got tag=%h hits=%0d want tag=%h hits=%0d", i, r_tag, r_hits, tags[i], hits[i]);
      end
    end
  endtask

  task automatic test_chain();
    send(3'd5, 1'b1, 2'b00, 1'b1, 32'h0, 32'hDEADBEEF, 32'h0000000F, 0);
    model(3'd5, 2'b00, 32'h0000000F);
    total++;
    if (lat !== 4 || ce_n !== 2 || i_tin !== 32'hDEADBEEF) begin
      bad++; $display("FAIL chain_timing got lat=%0d ce=%0d issue_tin=%h want 4/2/deadbeef", lat, ce_n, i_tin);
    end
    total++;
    if (u_mode !== 3'd1 || u_tin !== 32'h0000000F || u_upd !== 1'b1 || u_as !== 1'b0) begin
      bad++; $display("FAIL chain_update got mode=%0d tin=%h upd=%b as=%b want 1/0000000f/1/0", u_mode, u_tin, u_upd, u_as);
    end
    total++;
    if (r_tag !== 32'h0000000F || r_hits !== 6'd4) begin
      bad++; $display("FAIL chain_rsp got tag=%h hits=%0d want 0000000f/4", r_tag, r_hits);
    end
  endtask

  task automatic test_illegal();
    send(3'd7, 1'b1, 2'b00, 1'b1, 32'h0, 32'h0, 32'h55555555, 5);
    total++;
    if (lat !== 1 || ce_n !== 0 || r_err !== 1'b1) begin
      bad++; $display("FAIL illegal_rsp got lat=%0d ce=%0d err=%b want 1/0/1", lat, ce_n, r_err);
    end
    total++;
    if (!stable || rdy_seen || r_tag !== acc_m || !post_ok) begin
      bad++; $display("FAIL illegal_hold got stable=%b ready_seen=%b tag=%h post=%b want 1/0/%h/1", stable, rdy_seen, r_tag, post_ok, acc_m);
    end
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic ch, up;
    logic [1:0] am;
    logic [DW-1:0] d, t, to;
    int h;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom); ch = 1'($urandom); am = 2'($urandom); up = 1'($urandom);
      d = $urandom; t = $urandom; h = $urandom_range(0, 2);
      to = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
      c_as = 1'($urandom); c_ca = CW'($urandom); c_pa = PW'($urandom); c_cd = 2'($urandom); c_pd = 2'($urandom);
      send(op, ch, am, up, d, t, to, h);
      model(op, am, to);
      total++;
      if (lat != exp_lat(op, ch) || ce_n != exp_ce(op, ch) || r_err !== (op == 3'd7)) begin
        bad++; $display("FAIL rand%0d_timing op=%0d got lat=%0d ce=%0d err=%b want lat=%0d ce=%0d", i, op, lat, ce_n, r_err, exp_lat(op, ch), exp_ce(op, ch));
      end
      total++;
      if (r_tag !== acc_m || r_hits !== HW'($countones(acc_m)) || !stable || rdy_seen || !post_ok) begin
        bad++; $display("FAIL rand%0d_rsp op=%0d got tag=%h hits=%0d stable=%b post=%b want tag=%h", i, op, r_tag, r_hits, stable, post_ok, acc_m);
      end
      if (op != 3'd7) begin
        total++;
        if (i_mode !== op || i_as !== c_as || i_ca !== c_ca || i_pa !== c_pa || i_cd !== c_cd || i_pd !== c_pd || i_din !== d || i_tin !== t || i_upd !== up) begin
          bad++; $display("FAIL rand%0d_issue got mode=%0d as=%b ca=%h din=%h tin=%h want mode=%0d as=%b ca=%h din=%h tin=%h", i, i_mode, i_as, i_ca, i_din, i_tin, op, c_as, c_ca, d, t);
        end
      end
      if (op >= 3'd2 && op <= 3'd6 && ch) begin
        total++;
        if (u_mode !== 3'd1 || u_tin !== acc_m || u_upd !== up || u_as !== 1'b0) begin
          bad++; $display("FAIL rand%0d_update got mode=%0d tin=%h upd=%b want 1/%h/%b", i, u_mode, u_tin, u_upd, acc_m, up);
        end
      end
    end
  endtask

  task automatic test_reset_mid(input int at);
    logic seen;
    seen = 0;
    tag_src = $urandom;
    cmd_op = 3'd3; cmd_chain = 1; cmd_acc = 2'b00; cmd_valid = 1;
    @(posedge CLK); #1;
    cmd_valid = 0;
    repeat (at) @(negedge CLK);
    RST_N = 0;
    #1;
    total++;
    if (sa_chip_enable !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      bad++; $display("FAIL reset_mid%0d got ce=%b valid=%b ready=%b want 0/0/0", at, sa_chip_enable, rsp_valid, cmd_ready);
    end
    repeat (2) @(negedge CLK);
    RST_N = 1;
    acc_m = 0;
    for (int k = 0; k < 4; k++) begin @(negedge CLK); if (rsp_valid || sa_chip_enable) seen = 1; end
    total++;
    if (seen || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL reset_mid%0d_idle got stale=%b ready=%b want 0/1", at, seen, cmd_ready);
    end
    send(3'd2, 1'b0, 2'b01, 1'b0, 32'h0, 32'h0, $urandom | 32'h1, 0);
    model(3'd2, 2'b01, 32'h1);
    total++;
    if (r_tag !== 32'h0 || r_hits !== 0 || lat != 3) begin
      bad++; $display("FAIL reset_mid%0d_acc got tag=%h hits=%0d lat=%0d want 0/0/3", at, r_tag, r_hits, lat);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_search();
    test_chain();
    test_illegal();
    test_random();
    test_reset_mid(2);
    test_reset_mid(1);
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
